// File: rtl/mul32_seq_pkg.sv
// Shared encodings and sizing for the sequential shift-and-add multiplier.
package mul32_seq_pkg;

  localparam int MUL_STEPS = 32;
  localparam int CNT_W     = 5;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/add32.sv
// 32-bit adder with no carry out; overflow wraps mod 2^32.
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mul32_seq.sv
// Iterative shift-and-add multiplier: one add32 accumulates one partial product
// per clock, returning the low 32 bits of a*b.
module mul32_seq
  import mul32_seq_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_t       state, state_nxt;
  logic [31:0]      acc, mcand, mplier;
  logic [CNT_W-1:0] count;
  logic [31:0]      add_sum, acc_nxt;
  logic             last_step;

  add32 u_add (
    .a   (acc),
    .b   (mcand),
    .sum (add_sum)
  );

  assign acc_nxt = mplier[0] ? add_sum : acc;

  // With early exit, the step that consumes the top remaining set bit ends the run.
  assign last_step = (count == LAST_STEP) ||
                     (EARLY_EXIT && ((mplier >> 1) == 32'd0));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      ST_RUN:           state_nxt = last_step ? ST_DONE : ST_RUN;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_RUN);
      done <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
          end
        end
        ST_RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (last_step) product <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_seq.sv
// Directed bench for mul32_seq: one instance per EARLY_EXIT setting.
module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [31:0] a0, b0, a1, b1;
  logic        busy0, done0, busy1, done1;
  logic [31:0] product0, product1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul32_seq #(.EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .product(product0)
  );

  mul32_seq #(.EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .product(product1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle and waits for done; checks latency, product and pulse width.
  task automatic run_op(input bit ee, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_p, input int exp_k, input string nm);
    int n;
    logic dn;
    if (ee) begin a1 = av; b1 = bv; start1 = 1'b1; end
    else    begin a0 = av; b0 = bv; start0 = 1'b1; end
    cyc();
    start0 = 1'b0;
    start1 = 1'b0;
    n  = 0;
    dn = ee ? done1 : done0;
    while (!dn && n < 40) begin
      cyc();
      n++;
      dn = ee ? done1 : done0;
    end
    checks++;
    if (dn !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout done=%b after %0d cycles, required 1", nm, dn, n);
    end
    checks++;
    if (n !== exp_k) begin
      errors++;
      $display("FAIL %s_latency got %0d cycles, required %0d", nm, n, exp_k);
    end
    checks++;
    if ((ee ? product1 : product0) !== exp_p) begin
      errors++;
      $display("FAIL %s_product got %h, required %h", nm, ee ? product1 : product0, exp_p);
    end
    cyc();
    checks++;
    if ((ee ? done1 : done0) !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse done still %b, required 0", nm, ee ? done1 : done0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if ({busy0, done0, busy1, done1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b, required 0000", {busy0, done0, busy1, done1});
    end
    checks++;
    if (product0 !== 32'd0 || product1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_product got %h/%h, required 0/0", product0, product1);
    end
  endtask

  task automatic test_basic();
    int n, busyc;
    a0 = 32'd7; b0 = 32'd6; start0 = 1'b1;
    cyc();
    start0 = 1'b0;
    n = 0; busyc = 0;
    while (!done0 && n < 40) begin
      if (busy0) busyc++;
      cyc();
      n++;
    end
    checks++;
    if (busyc !== 32) begin
      errors++;
      $display("FAIL basic_busy got %0d busy cycles, required 32", busyc);
    end
    checks++;
    if (n !== 32 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_done done=%b at %0d, required 1 at 32", done0, n);
    end
    checks++;
    if (product0 !== 32'd42) begin
      errors++;
      $display("FAIL basic_product got %0d, required 42", product0);
    end
    cyc();
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle done=%b busy=%b, required 0 0", done0, busy0);
    end
  endtask

  task automatic test_wrap();
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, "wrap_ones");
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32, "wrap_pow16");
    run_op(1'b0, 32'd1234, 32'd0, 32'd0, 32, "fixed_b0");
    run_op(1'b0, 32'h1234_5678, 32'd16, 32'h2345_6780, 32, "fixed_shift");
  endtask

  task automatic test_back_to_back();
    int n;
    a0 = 32'd3; b0 = 32'd5; start0 = 1'b1;
    cyc();
    a0 = 32'd100; b0 = 32'd100;
    for (int i = 0; i < 20; i++) cyc();
    a0 = 32'd9; b0 = 32'd9;
    n = 20;
    while (!done0 && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (done0 !== 1'b1 || product0 !== 32'd15 || n !== 32) begin
      errors++;
      $display("FAIL b2b_first done=%b product=%0d at %0d, required 1 15 at 32", done0, product0, n);
    end
    cyc();
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bubble busy=%b done=%b, required 1 0", busy0, done0);
    end
    start0 = 1'b0;
    a0 = 32'd2; b0 = 32'd2;
    for (int i = 0; i < 10; i++) cyc();
    checks++;
    if (product0 !== 32'd15) begin
      errors++;
      $display("FAIL b2b_hold product mid-run %0d, required 15", product0);
    end
    n = 10;
    while (!done0 && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (done0 !== 1'b1 || product0 !== 32'd81 || n !== 32) begin
      errors++;
      $display("FAIL b2b_second done=%b product=%0d at %0d, required 1 81 at 32", done0, product0, n);
    end
    cyc();
  endtask

  task automatic test_early_exit();
    run_op(1'b1, 32'd123, 32'd0, 32'd0, 1, "ee_b0");
    run_op(1'b1, 32'h11, 32'h8, 32'h88, 4, "ee_b8");
    run_op(1'b1, 32'd3, 32'h8000_0000, 32'h8000_0000, 32, "ee_msb");
    run_op(1'b1, 32'd5, 32'd1, 32'd5, 1, "ee_b1");
  endtask

  task automatic test_reset_abort();
    int seen;
    a0 = 32'd5; b0 = 32'd5; start0 = 1'b1;
    cyc();
    start0 = 1'b0;
    for (int i = 0; i < 9; i++) cyc();
    reset = 1'b1;
    start0 = 1'b1;
    cyc();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || product0 !== 32'd0) begin
      errors++;
      $display("FAIL abort_state busy=%b done=%b product=%h, required 0 0 0", busy0, done0, product0);
    end
    reset = 1'b0;
    start0 = 1'b0;
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      cyc();
      if (done0 || busy0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles, required 0", seen);
    end
    run_op(1'b0, 32'd5, 32'd5, 32'd25, 32, "abort_restart");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_early_exit();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
